// File: rtl/mem_scan_display.sv
// rtl/mem_scan_display.sv - memory word browser with multiplexed active-low 7-segment hex display
// Optional feature macro: MEM_DISP_AUTOSTEP_EN (periodic implicit step while idle and enabled)
module mem_scan_display #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int DIGITS   = 8,
  parameter int READ_LAT = 1,
  parameter int SCAN_DIV = 1024,
  parameter int AUTO_DIV = 1 << 20
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              ena,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [DATA_W-1:0] word_out,
  output logic              rd_done,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] ans
);

  localparam int LAT_W  = $clog2(READ_LAT + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              capture;
  logic              step_req;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        nibble;

`ifdef MEM_DISP_AUTOSTEP_EN
  localparam int AUTO_W = $clog2(AUTO_DIV);
  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_req;

  // Idle-time counter; raises a one-cycle implicit step, explicit requests restart it
  always_ff @(posedge clka) begin
    if (rst) begin
      auto_cnt <= '0;
      auto_req <= 1'b0;
    end else begin
      auto_req <= 1'b0;
      if (accept) begin
        auto_cnt <= '0;
      end else if (ena && state == S_IDLE) begin
        if (auto_cnt == AUTO_W'(AUTO_DIV - 1)) begin
          auto_cnt <= '0;
          auto_req <= 1'b1;
        end else begin
          auto_cnt <= auto_cnt + 1'b1;
        end
      end
    end
  end

  assign step_req = step | auto_req;
`else
  assign step_req = step;
`endif

  // Requests are only taken while idle; anything arriving during a read is dropped
  assign accept   = (state == S_IDLE) && ena && (load || step_req);
  assign busy     = (state != S_IDLE);
  assign mem_addr = cur_addr;

  // State register
  always_ff @(posedge clka) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, read strobe and capture decision
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: begin
        mem_en    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  if (lat_cnt == LAT_W'(READ_LAT - 1)) begin
        capture   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counts cycles spent in WAIT so capture lands READ_LAT cycles after the strobe
  always_ff @(posedge clka) begin
    if (rst)                         lat_cnt <= '0;
    else if (state == S_WAIT && !capture) lat_cnt <= lat_cnt + 1'b1;
    else                             lat_cnt <= '0;
  end

  // Current address: load takes priority, step wraps naturally at all-ones
  always_ff @(posedge clka) begin
    if (rst)         cur_addr <= '0;
    else if (accept) cur_addr <= load ? addr_in : cur_addr + 1'b1;
  end

  // Captured word and its one-cycle update pulse
  always_ff @(posedge clka) begin
    if (rst) begin
      word_out <= '0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= capture;
      if (capture) word_out <= mem_dout;
    end
  end

  // Free-running digit scan, independent of the read engine
  always_ff @(posedge clka) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign ans    = ~(DIGITS'(1) << idx);
  assign nibble = word_out[4*idx +: 4];

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Registered segment decode of the currently selected nibble
  always_ff @(posedge clka) begin
    if (rst) seg <= 7'b1000000;
    else     seg <= hex7(nibble);
  end

endmodule
